// File: rtl/band_pkg.sv
// -----------------------------------------------------------------------------
// band_pkg
// Shared constants and types for the EEG band-power blocks (delta/theta/alpha/
// beta). Each band-power block squares its filtered samples, averages them over
// a power-of-two window and saturates the mean to a 32-bit unsigned result.
// No ports: package only.
// -----------------------------------------------------------------------------
package band_pkg;

  // Width of the signed filtered sample delivered by the band IIR filters.
  localparam int DATA_W   = 32;
  // Default log2 of the averaging window (256 samples).
  localparam int LOG2_WIN = 8;
  // Width of the reported power value and its saturation ceiling.
  localparam int POWER_W  = 32;
  localparam logic [POWER_W-1:0] POWER_MAX = 32'hFFFF_FFFF;

  // Band identifier, shared by the sibling power blocks.
  typedef enum logic [1:0] {
    BAND_DELTA = 2'd0,
    BAND_THETA = 2'd1,
    BAND_ALPHA = 2'd2,
    BAND_BETA  = 2'd3
  } band_id_e;

endpackage : band_pkg

// File: rtl/square_accum.sv
// -----------------------------------------------------------------------------
// square_accum
// Two-stage datapath: stage 1 registers sample*sample, stage 2 accumulates the
// squares and counts them. On the last square of a window it raises win_done_o
// for one cycle with win_sum_o = full window sum (accumulator plus the final
// square), then restarts the window in the same cycle.
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   clear_i         synchronous window restart; drops the in-flight square
//   sample_valid_i  qualifies sample_i
//   sample_i        signed filtered sample
//   win_done_o      window completes this cycle (combinational from registers)
//   win_sum_o       sum of all squares of the completing window
// -----------------------------------------------------------------------------
module square_accum #(
  parameter int  DATA_W   = 32,
  parameter int  LOG2_WIN = 8,
  localparam int SQ_W     = 2 * DATA_W,
  localparam int ACC_W    = SQ_W + LOG2_WIN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              win_done_o,
  output logic [ACC_W-1:0]  win_sum_o
);

  localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

  logic [SQ_W-1:0]     sq_q,  sq_d;
  logic                sq_v_q, sq_v_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;

  logic signed [SQ_W-1:0] sample_ext_s;
  logic signed [SQ_W-1:0] sq_full_s;
  logic [ACC_W-1:0]       sum_s;
  logic                   win_done_s;

  // Sign-extend to the product width so the multiply is exact; the square of
  // the most negative sample (2^(2*DATA_W-2)) still fits in SQ_W bits.
  assign sample_ext_s = {{DATA_W{sample_i[DATA_W-1]}}, sample_i};
  assign sq_full_s    = sample_ext_s * sample_ext_s;
  assign sum_s        = acc_q + ACC_W'(sq_q);

  // Next-state for square stage, accumulator and window counter.
  always_comb begin
    sq_d       = sq_q;
    sq_v_d     = 1'b0;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    win_done_s = 1'b0;
    if (clear_i) begin
      // Restart window; the sample presented with clear and the square in
      // flight are both discarded.
      sq_v_d = 1'b0;
      acc_d  = '0;
      cnt_d  = '0;
    end else begin
      if (sample_valid_i) begin
        sq_d   = $unsigned(sq_full_s);
        sq_v_d = 1'b1;
      end else begin
        sq_d   = sq_q;
        sq_v_d = 1'b0;
      end
      if (sq_v_q) begin
        if (cnt_q == CNT_LAST) begin
          win_done_s = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
        end else begin
          acc_d = sum_s;
          cnt_d = cnt_q + LOG2_WIN'(1);
        end
      end else begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_q   <= '0;
      sq_v_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      sq_q   <= sq_d;
      sq_v_q <= sq_v_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign win_done_o = win_done_s;
  assign win_sum_o  = sum_s;

endmodule : square_accum

// File: rtl/theta_band_power.sv
// -----------------------------------------------------------------------------
// theta_band_power
// Mean power of the 4-8 Hz filtered signal over windows of 2^LOG2_WIN valid
// samples, further scaled by 2^-OUT_SHIFT and saturated to 32 bits. Results
// leave through a valid/ready register stage with a threshold flag.
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   clear         synchronous window restart (pending result untouched)
//   sample_valid  qualifies sample (no input backpressure)
//   sample        signed filtered sample
//   threshold     unsigned threshold, sampled when a result loads
//   power_valid   result available
//   power_ready   downstream accepts result
//   power         saturated mean power
//   above_thresh  power > threshold for this result
//   sat           power was clipped for this result
//   overrun       sticky: an unaccepted result was overwritten
// -----------------------------------------------------------------------------
module theta_band_power #(
  parameter int DATA_W    = band_pkg::DATA_W,
  parameter int LOG2_WIN  = band_pkg::LOG2_WIN,
  parameter int OUT_SHIFT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         sample_valid,
  input  logic [DATA_W-1:0]            sample,
  input  logic [band_pkg::POWER_W-1:0] threshold,
  output logic                         power_valid,
  input  logic                         power_ready,
  output logic [band_pkg::POWER_W-1:0] power,
  output logic                         above_thresh,
  output logic                         sat,
  output logic                         overrun
);

  import band_pkg::*;

  localparam int ACC_W = 2 * DATA_W + LOG2_WIN;
  localparam int SHIFT = LOG2_WIN + OUT_SHIFT;

  logic               win_done_s;
  logic [ACC_W-1:0]   win_sum_s;
  logic [ACC_W-1:0]   mean_s;
  logic               clip_s;
  logic [POWER_W-1:0] clipped_s;
  logic               above_s;

  logic               valid_q, valid_d;
  logic [POWER_W-1:0] power_q, power_d;
  logic               above_q, above_d;
  logic               sat_q,   sat_d;
  logic               ovr_q,   ovr_d;

  square_accum #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) u_square_accum (
    .clk_i          (clk),
    .rst_ni         (reset),
    .clear_i        (clear),
    .sample_valid_i (sample_valid),
    .sample_i       (sample),
    .win_done_o     (win_done_s),
    .win_sum_o      (win_sum_s)
  );

  // Dividing by the window length is a shift because the window is 2^LOG2_WIN.
  assign mean_s    = win_sum_s >> SHIFT;
  assign clip_s    = (mean_s > ACC_W'(POWER_MAX));
  assign clipped_s = clip_s ? POWER_MAX : mean_s[POWER_W-1:0];
  assign above_s   = (clipped_s > threshold);

  // Output register and handshake: a new result always wins over a transfer.
  always_comb begin
    valid_d = valid_q;
    power_d = power_q;
    above_d = above_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    if (win_done_s) begin
      valid_d = 1'b1;
      power_d = clipped_s;
      above_d = above_s;
      sat_d   = clip_s;
      // Overwriting a result that was never accepted is recorded; a result
      // leaving in the same cycle is not an overrun.
      if (valid_q && !power_ready) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end else if (valid_q && power_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      power_q <= '0;
      above_q <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      power_q <= power_d;
      above_q <= above_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end

  assign power_valid  = valid_q;
  assign power        = power_q;
  assign above_thresh = above_q;
  assign sat          = sat_q;
  assign overrun      = ovr_q;

endmodule : theta_band_power

// File: doc/theta_band_power.md
Name: theta_band_power

Overview:
- Consumer of the theta-band IIR filter output.
- Squares each filtered sample, accumulates over a fixed window of 2^LOG2_WIN valid samples, and emits the mean band power with a valid/ready handshake plus a threshold flag.
- Sits directly downstream of the 4-8 Hz filter and feeds the detection and classification logic.

Parameters:
- DATA_W, 32: width of the signed input sample.
- LOG2_WIN, 8: log2 of window length in samples (window = 256 by default); legal range 1..16.
- OUT_SHIFT, 16: extra right shift applied after averaging, before saturation to 32 bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- clear  input  1  synchronous; restarts the current window and drops any in-flight sample.
- sample_valid  input  1  qualifies sample; one sample consumed per cycle it is high (no backpressure on input).
- sample  input  DATA_W  signed filtered sample (filter y).
- threshold  input  32  unsigned power threshold, sampled with the result.
- power_valid  output  1  result available.
- power_ready  input  1  downstream accepts the result.
- power  output  32  unsigned mean power, saturated.
- above_thresh  output  1  power > threshold, registered with power.
- sat  output  1  power was clipped to 0xFFFFFFFF for this result.
- overrun  output  1  sticky: a result was overwritten before acceptance.

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following to 0:
  - power, power_valid, above_thresh, sat, overrun;
  - accumulator, sample counter, pipeline valids.
- Stage 1 (square):
  - On sample_valid, register sq = sample*sample as an unsigned 2*DATA_W value.
  - -2^31 squared = 2^62 fits without overflow.
  - Set sq_v.
- Stage 2 (accumulate):
  - On sq_v, acc += sq and cnt += 1.
  - acc width = 2*DATA_W + LOG2_WIN, so it never wraps.
  - cnt is a LOG2_WIN-bit counter.
  - When sq_v and cnt == 2^LOG2_WIN-1, this is the window end:
    - compute m = (acc + sq) >> (LOG2_WIN + OUT_SHIFT);
    - load power = (m > 0xFFFFFFFF) ? 0xFFFFFFFF : m[31:0];
    - load sat = (m > 0xFFFFFFFF);
    - load above_thresh = (power_loaded > threshold);
    - set power_valid;
    - reset acc to 0 and wrap cnt to 0 in the same cycle.
- Latency: the sample accepted in cycle N that completes a window produces power_valid=1 in cycle N+2 (i.e. visible after the second posedge).
- Handshake:
  - power, sat and above_thresh are held stable while power_valid=1 and power_ready=0.
  - The transfer occurs on a posedge with power_valid=1 and power_ready=1; power_valid drops next cycle unless a new result loads in that same cycle.
- Simultaneous events:
  - New result + transfer in the same cycle: new result loads, power_valid stays 1, overrun unchanged.
  - New result while power_valid=1 and power_ready=0: new result overwrites the old one, power_valid stays 1, overrun set.
  - overrun is cleared only by reset.
- clear:
  - Zeroes acc, cnt and sq_v next cycle. The sample present with clear is discarded.
  - Does not affect a pending result, power_valid or overrun.
- Back-to-back samples on every cycle are supported. Gaps in sample_valid simply stall the count.
- Reset mid-window discards partial accumulation. No result is emitted for a partial window.

Decomposition:
- Shared package band_pkg:
  - DATA_W, default LOG2_WIN, POWER_W=32, the saturation constant POWER_MAX=32'hFFFFFFFF;
  - a band-id enum (delta/theta/alpha/beta) for later reuse by sibling power blocks.
- One natural sub-module: square_accum (stage 1 + stage 2 + window counter).
- The top adds the output register, handshake, threshold compare and overrun logic.

Test Plan:
- LOG2_WIN=3, OUT_SHIFT=0; 8 consecutive samples of 1024, power_ready=1 → power_valid one cycle, 2 cycles after the 8th sample; power=1048576, sat=0.
- LOG2_WIN=3, OUT_SHIFT=0; 8 samples of -2^31 → power=0xFFFFFFFF, sat=1; with threshold=0xFFFFFFFE, above_thresh=1.
- Alternating +100/-100 with sample_valid toggling every other cycle, LOG2_WIN=3 → exactly one result, power=10000, after the 8th valid sample.
- power_ready=0 across two full windows (samples 10, then 20) → power holds 100 through the first window's hold; the second window's completion shows power=400 and overrun=1; power_ready=1 → power_valid drops next cycle, overrun stays 1.
- clear asserted after 5 of 8 samples of 50, then 8 samples of 3 → single result power=9; no result from the first 5 samples.
- reset=0 asynchronously mid-window and while power_valid=1 → all outputs 0 immediately; the next full window of 7s gives power=49.
